weight_pingpong_buffer: RTL and testbench
=========================================

Name: weight_pingpong_buffer

Overview:
- Double-buffered weight store feeding the systolic array. Weights load row by row into a shadow bank through a valid/ready handshake, while the active bank streams rows to the array on command.
- When the shadow bank is complete and the drain path is idle, the banks swap.
- Successor to the single-bank row store. Adds ping-pong banking, an auto-incrementing load pointer, a sequenced drain with forward/reverse order, and optional faulty-column masking.

Parameters:
ROWS, 8, rows per bank (array height)
COLS, 8, weights per row (array width)
WEIGHT_WIDTH, 8, bits per weight
ADDR_WIDTH, $clog2(ROWS), row pointer width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ld_valid  input  1  load row valid
ld_ready  output  1  buffer accepts a load row (= !shadow_full)
ld_data  input  COLS*WEIGHT_WIDTH  load row; column c at bits [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
ld_row_idx  output  ADDR_WIDTH  shadow row written on the next handshake
drn_start  input  1  request one full drain of the active bank
drn_rev  input  1  drain order, sampled with an accepted drn_start; 0 = row 0 first, 1 = row ROWS-1 first
drn_busy  output  1  drain in progress
drn_valid  output  1  drn_data/drn_row valid this cycle
drn_row  output  ADDR_WIDTH  row index of drn_data
drn_data  output  COLS*WEIGHT_WIDTH  drained row, registered; zero when drn_valid=0
drn_last  output  1  high with the final row of a drain
bank_sel  output  1  index of the active bank
shadow_full  output  1  shadow bank holds a complete, unswapped set
active_valid  output  1  active bank holds a complete set

Behaviour:
- Reset:
  - All outputs 0.
  - act_sel=0, wr_ptr=0, shadow_full=0, active_valid=0, FSM=IDLE.
  - ld_ready becomes 1 the cycle after reset deasserts.
  - Memory contents are not reset.
- Load:
  - A handshake (ld_valid & ld_ready) writes ld_data to shadow bank row wr_ptr, then wr_ptr increments.
  - On the handshake at wr_ptr==ROWS-1: wr_ptr wraps to 0 and shadow_full sets (visible next cycle).
  - ld_valid with ld_ready=0 writes nothing; the pointer holds.
  - Loading continues during a drain; the active bank is never written.
- Drain FSM states: IDLE, STREAM.
  - IDLE with drn_start & active_valid: accept, latch drn_rev, go to STREAM, drn_busy=1 next cycle.
  - IDLE with drn_start & !active_valid: ignored.
  - drn_start while in STREAM: ignored.
- Drain timing (start accepted at edge T):
  - drn_valid=1 for the ROWS cycles following T.
  - drn_row runs 0..ROWS-1 (drn_rev=0) or ROWS-1..0 (drn_rev=1).
  - drn_data equals the active bank row at drn_row.
  - drn_last=1 with the final row; FSM returns to IDLE on that edge; drn_busy=0 the cycle after.
  - No backpressure. The active bank stays valid after a drain, so it can be re-drained.
- Swap:
  - Condition, evaluated in IDLE only: shadow_full=1 and no drn_start accepted that cycle.
  - On swap: act_sel toggles, shadow_full clears, active_valid sets.
  - An accepted drn_start has priority over a swap; the swap waits for the next idle cycle.
  - Never swap during STREAM.
- Simultaneous events:
  - Final load handshake and drain completion in the same cycle: the swap occurs no earlier than the following cycle.
  - A new load into the freed shadow bank may start the cycle after the swap.
- Reset mid-operation: the drain aborts with no drn_last; any partial load is discarded (wr_ptr=0).

Optional Feature:
- Macro: WEIGHT_BUF_FAULT_MASK_EN.
- With the macro defined:
  - Input port col_fault_mask [COLS-1:0] is present, driven by BISR.
  - Each column c with the mask bit set outputs 0 on drn_data.
  - The mask is sampled in the same registered stage as drn_data, with no added latency.
  - Stored weights are unaltered.
- Without the macro: the port is absent and drn_data passes unmasked.

Decomposition:
- Package weight_buf_pkg holds:
  - FSM state enum (IDLE, STREAM).
  - Localparam ROW_W = COLS*WEIGHT_WIDTH.
  - Function col_slice helper.
- Sub-module weight_bank, instantiated twice:
  - Write port: we, waddr, wdata.
  - Combinational read port: raddr → rdata.
  - Bank write enable = handshake & (bank index != act_sel).

Test Plan:
- Reset, then load 8 rows with row r, col c = 8r+c → shadow_full=1, then swap (bank_sel 0→1, active_valid=1); ld_ready=0 between the last handshake and the swap.
- drn_start with drn_rev=0 → drn_valid for 8 cycles, drn_row 0..7, data matches; drn_last on row 7; drn_busy clears the next cycle.
- drn_rev=1 → rows 7..0 in order, drn_last on row 0; a second drn_start mid-stream is ignored.
- Fill the second set (all weights 0xA5) during a drain → no swap until drain end; bank_sel toggles on the first idle cycle; a re-drain returns 0xA5 everywhere.
- drn_start with active_valid=0 → no response. Assert rst at drain row 3 → drn_valid=0 next cycle, all flags cleared, no drn_last.
- With WEIGHT_BUF_FAULT_MASK_EN defined and mask=8'b0000_0101 → columns 0 and 2 read 0, others unchanged. Clear the mask and re-drain → original data returns.

Source files
------------

// File: rtl/weight_buf_pkg.sv
// Shared types and helpers for the ping-pong weight buffer.
// Holds the drain FSM state enum, the default row width and a column slicer.
// Contents: drn_state_t, ROW_W, col_slice().
package weight_buf_pkg;

    localparam int ROWS_DEF         = 8;
    localparam int COLS_DEF         = 8;
    localparam int WEIGHT_WIDTH_DEF = 8;
    localparam int ROW_W            = COLS_DEF * WEIGHT_WIDTH_DEF;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drn_state_t;

    // Extract weight column c from a packed row at the default geometry.
    function automatic logic [WEIGHT_WIDTH_DEF-1:0] col_slice(input logic [ROW_W-1:0] row,
                                                              input int unsigned     c);
        return row[c*WEIGHT_WIDTH_DEF +: WEIGHT_WIDTH_DEF];
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One bank of row storage: synchronous write port, combinational read port.
// Latency: write visible the cycle after we; read is same-cycle.
// Backpressure: none, always accepts a write. Ports: clk, we/waddr/wdata, raddr/rdata.
module weight_bank
    import weight_buf_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int ROW_W      = 64,
    parameter int ADDR_WIDTH = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ROW_W-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [ROW_W-1:0]      rdata
);

    // Storage is deliberately not reset; a bank is only read once fully loaded.
    logic [ROW_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store: rows load into the shadow bank while the active bank drains.
// Latency: drained rows start the cycle after an accepted drn_start, one row per cycle.
// Backpressure: ld_ready drops while the shadow bank is full and unswapped; drain has none.
// Ports: clk/rst; ld_valid/ld_ready/ld_data/ld_row_idx load side; drn_* drain side;
// bank_sel/shadow_full/active_valid status. Optional WEIGHT_BUF_FAULT_MASK_EN adds
// col_fault_mask, which zeroes masked columns of drn_data.
module weight_pingpong_buffer
    import weight_buf_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_WIDTH   = $clog2(ROWS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [COLS*WEIGHT_WIDTH-1:0] ld_data,
    output logic [ADDR_WIDTH-1:0]        ld_row_idx,
    input  logic                         drn_start,
    input  logic                         drn_rev,
`ifdef WEIGHT_BUF_FAULT_MASK_EN
    input  logic [COLS-1:0]              col_fault_mask,
`endif
    output logic                         drn_busy,
    output logic                         drn_valid,
    output logic [ADDR_WIDTH-1:0]        drn_row,
    output logic [COLS*WEIGHT_WIDTH-1:0] drn_data,
    output logic                         drn_last,
    output logic                         bank_sel,
    output logic                         shadow_full,
    output logic                         active_valid
);

    localparam int                    DW       = COLS * WEIGHT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

    drn_state_t            state, state_nxt;
    logic                  act_sel;
    logic                  rev;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  hs, accept, swap, sf_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr, end_row;
    logic [DW-1:0]         rdata0, rdata1, rdata_act, col_keep;

    assign hs = ld_valid & ld_ready;

    // ---------------- drain FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // rd_addr is the row that will be registered onto drn_data at the next edge.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        swap      = 1'b0;
        rd_addr   = drn_row;
        end_row   = LAST_ROW;
        case (state)
            IDLE: begin
                rd_addr = drn_rev ? LAST_ROW : '0;
                end_row = drn_rev ? '0 : LAST_ROW;
                if (drn_start && active_valid) begin
                    accept    = 1'b1;
                    state_nxt = STREAM;
                end else if (shadow_full) begin
                    // A start accepted this cycle wins; the swap waits for a free idle cycle.
                    swap = 1'b1;
                end
            end
            STREAM: begin
                rd_addr = rev ? drn_row - 1'b1 : drn_row + 1'b1;
                end_row = rev ? '0 : LAST_ROW;
                if (drn_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- load pointer, bank status ----------------
    // A handshake can never coincide with a swap: ld_ready is low whenever shadow_full is set.
    assign sf_nxt = swap ? 1'b0 : ((hs && wr_ptr == LAST_ROW) ? 1'b1 : shadow_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            act_sel      <= 1'b0;
            wr_ptr       <= '0;
            shadow_full  <= 1'b0;
            active_valid <= 1'b0;
            ld_ready     <= 1'b0;
            rev          <= 1'b0;
        end else begin
            if (hs) wr_ptr <= (wr_ptr == LAST_ROW) ? '0 : wr_ptr + 1'b1;
            if (accept) rev <= drn_rev;
            if (swap) begin
                act_sel      <= ~act_sel;
                active_valid <= 1'b1;
            end
            shadow_full <= sf_nxt;
            // Registered so that it stays low throughout reset and rises one cycle after.
            ld_ready    <= ~sf_nxt;
        end
    end

    // ---------------- banks ----------------
    weight_bank #(.ROWS(ROWS), .ROW_W(DW), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
        .clk   (clk),
        .we    (hs & act_sel),
        .waddr (wr_ptr),
        .wdata (ld_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    weight_bank #(.ROWS(ROWS), .ROW_W(DW), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
        .clk   (clk),
        .we    (hs & ~act_sel),
        .waddr (wr_ptr),
        .wdata (ld_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rdata_act = act_sel ? rdata1 : rdata0;

`ifdef WEIGHT_BUF_FAULT_MASK_EN
    always_comb begin
        col_keep = '0;
        for (int c = 0; c < COLS; c++) begin
            col_keep[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = {WEIGHT_WIDTH{~col_fault_mask[c]}};
        end
    end
`else
    assign col_keep = '1;
`endif

    // ---------------- registered drain outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drn_valid <= 1'b0;
            drn_row   <= '0;
            drn_data  <= '0;
            drn_last  <= 1'b0;
        end else if (accept || (state == STREAM && !drn_last)) begin
            drn_valid <= 1'b1;
            drn_row   <= rd_addr;
            drn_data  <= rdata_act & col_keep;
            drn_last  <= (rd_addr == end_row);
        end else if (state == STREAM) begin
            drn_valid <= 1'b0;
            drn_data  <= '0;
            drn_last  <= 1'b0;
        end
    end

    assign drn_busy   = (state == STREAM);
    assign ld_row_idx = wr_ptr;
    assign bank_sel   = act_sel;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer: vector table for load/swap/forward drain,
// hand sequences for reverse drain, load-during-drain swap timing, re-drain, optional
// column masking, ignored starts and reset mid-drain.
module tb_weight_pingpong_buffer;
    import weight_buf_pkg::*;

    localparam int R  = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic [2:0]    ld_row_idx;
    logic          drn_start;
    logic          drn_rev;
    logic          drn_busy;
    logic          drn_valid;
    logic [2:0]    drn_row;
    logic [DW-1:0] drn_data;
    logic          drn_last;
    logic          bank_sel;
    logic          shadow_full;
    logic          active_valid;
`ifdef WEIGHT_BUF_FAULT_MASK_EN
    logic [7:0]    col_fault_mask;
`endif

    weight_pingpong_buffer #(.ROWS(8), .COLS(8), .WEIGHT_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .ld_row_idx     (ld_row_idx),
        .drn_start      (drn_start),
        .drn_rev        (drn_rev),
`ifdef WEIGHT_BUF_FAULT_MASK_EN
        .col_fault_mask (col_fault_mask),
`endif
        .drn_busy       (drn_busy),
        .drn_valid      (drn_valid),
        .drn_row        (drn_row),
        .drn_data       (drn_data),
        .drn_last       (drn_last),
        .bank_sel       (bank_sel),
        .shadow_full    (shadow_full),
        .active_valid   (active_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          ldv;
        logic [DW-1:0] ldd;
        logic          ds;
        logic          dr;
        logic          e_rdy;
        logic [2:0]    e_idx;
        logic          e_full;
        logic          e_sel;
        logic          e_act;
        logic          e_dv;
        logic [2:0]    e_drow;
        logic          e_last;
        logic          e_busy;
        logic [DW-1:0] e_data;
    } vec_t;

    localparam logic [DW-1:0] A5S = {8{8'hA5}};

    function automatic logic [DW-1:0] pat(input int r);
        logic [DW-1:0] v;
        for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(8*r + c);
        return v;
    endfunction

    function automatic vec_t mk(input logic ldv, input logic [DW-1:0] ldd, input logic ds,
                                input logic dr, input logic rdy, input logic [2:0] idx,
                                input logic full, input logic sel, input logic act,
                                input logic dv, input logic [2:0] drow, input logic last,
                                input logic busy, input logic [DW-1:0] data);
        vec_t v;
        v.ldv = ldv;  v.ldd = ldd;   v.ds = ds;       v.dr = dr;
        v.e_rdy = rdy; v.e_idx = idx; v.e_full = full; v.e_sel = sel; v.e_act = act;
        v.e_dv = dv;  v.e_drow = drow; v.e_last = last; v.e_busy = busy; v.e_data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input logic rdy, input logic [2:0] idx,
                             input logic full, input logic sel, input logic act);
        chk({nm, ".ld_ready"},     64'(ld_ready),     64'(rdy));
        chk({nm, ".ld_row_idx"},   64'(ld_row_idx),   64'(idx));
        chk({nm, ".shadow_full"},  64'(shadow_full),  64'(full));
        chk({nm, ".bank_sel"},     64'(bank_sel),     64'(sel));
        chk({nm, ".active_valid"}, 64'(active_valid), 64'(act));
    endtask

    task automatic chk_drn(input string nm, input logic dv, input logic [2:0] row,
                           input logic last, input logic busy, input logic [DW-1:0] data);
        chk({nm, ".drn_valid"}, 64'(drn_valid), 64'(dv));
        if (dv) chk({nm, ".drn_row"}, 64'(drn_row), 64'(row));
        chk({nm, ".drn_last"},  64'(drn_last),  64'(last));
        chk({nm, ".drn_busy"},  64'(drn_busy),  64'(busy));
        chk({nm, ".drn_data"},  drn_data,       data);
    endtask

    vec_t tbl[18];

    initial begin
        // Load 8 pattern rows, swap, then drain forward.
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(1, pat(k), 0, 0, (k != 7), 3'((k + 1) % 8), (k == 7), 0, 0,
                        0, 0, 0, 0, '0);
        // ld_valid held while ld_ready=0: no write, swap happens this edge.
        tbl[8] = mk(1, '1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, '0);
        tbl[9] = mk(0, '0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, pat(0));
        for (int k = 10; k < 17; k++)
            tbl[k] = mk(0, '0, 0, 0, 1, 0, 0, 1, 1, 1, 3'(k - 9), (k == 16), 1, pat(k - 9));
        tbl[17] = mk(0, '0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, '0);

        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; drn_start = 1'b0; drn_rev = 1'b0;
`ifdef WEIGHT_BUF_FAULT_MASK_EN
        col_fault_mask = '0;
`endif
        step();
        step();
        chk_flags("reset", 0, 0, 0, 0, 0);
        chk_drn("reset", 0, 0, 0, 0, '0);
        rst = 1'b0;
        step();
        chk("post_reset.ld_ready", 64'(ld_ready), 64'd1);

        for (int i = 0; i < 18; i++) begin
            ld_valid  = tbl[i].ldv;
            ld_data   = tbl[i].ldd;
            drn_start = tbl[i].ds;
            drn_rev   = tbl[i].dr;
            step();
            chk_flags($sformatf("t%0d", i), tbl[i].e_rdy, tbl[i].e_idx, tbl[i].e_full,
                      tbl[i].e_sel, tbl[i].e_act);
            chk_drn($sformatf("t%0d", i), tbl[i].e_dv, tbl[i].e_drow, tbl[i].e_last,
                    tbl[i].e_busy, tbl[i].e_data);
        end

        // Reverse drain with a forward start attempted mid-stream.
        drn_start = 1'b1; drn_rev = 1'b1;
        step();
        chk_drn("rev0", 1, 7, 0, 1, pat(7));
        for (int i = 1; i < 8; i++) begin
            drn_start = (i == 3);
            drn_rev   = 1'b0;
            step();
            chk_drn($sformatf("rev%0d", i), 1, 3'(7 - i), (i == 7), 1, pat(7 - i));
        end
        drn_start = 1'b0;
        step();
        chk_drn("rev_end", 0, 0, 0, 0, '0);

        // Fill the second set during a drain; last handshake lands on the drain-end edge.
        drn_start = 1'b1;
        step();
        chk_drn("fill0", 1, 0, 0, 1, pat(0));
        drn_start = 1'b0;
        ld_valid  = 1'b1;
        ld_data   = A5S;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 8) begin
                chk_drn($sformatf("fill%0d", i), 1, 3'(i), (i == 7), 1, pat(i));
                chk_flags($sformatf("fill%0d", i), 1, 3'(i), 0, 1, 1);
            end else begin
                chk_drn("fill8", 0, 0, 0, 0, '0);
                chk_flags("fill8", 0, 0, 1, 1, 1);
            end
        end
        ld_valid = 1'b0;
        step();
        chk_flags("swap2", 1, 0, 0, 0, 1);

        drn_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            drn_start = 1'b0;
            chk_drn($sformatf("a5_%0d", i), 1, 3'(i), (i == 7), 1, A5S);
        end
        step();
        chk_drn("a5_end", 0, 0, 0, 0, '0);

`ifdef WEIGHT_BUF_FAULT_MASK_EN
        col_fault_mask = 8'b0000_0101;
        drn_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            drn_start = 1'b0;
            for (int c = 0; c < 8; c++)
                chk($sformatf("mask_r%0d_c%0d", i, c), 64'(col_slice(drn_data, c)),
                    (c == 0 || c == 2) ? 64'h0 : 64'hA5);
        end
        step();
        col_fault_mask = '0;
        drn_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            drn_start = 1'b0;
            chk_drn($sformatf("unmask%0d", i), 1, 3'(i), (i == 7), 1, A5S);
        end
        step();
`endif

        // Partial load during a drain, then reset at row 3.
        drn_start = 1'b1;
        step();
        drn_start = 1'b0;
        ld_valid  = 1'b1;
        ld_data   = pat(9);
        step();
        step();
        ld_valid = 1'b0;
        step();
        chk_drn("pre_rst", 1, 3, 0, 1, A5S);
        chk("pre_rst.ld_row_idx", 64'(ld_row_idx), 64'd2);
        rst = 1'b1;
        step();
        chk_drn("mid_rst", 0, 0, 0, 0, '0);
        chk_flags("mid_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_flags("rst_rel", 1, 0, 0, 0, 0);

        // Start with no valid active bank is ignored.
        drn_start = 1'b1;
        step();
        chk_drn("nostart0", 0, 0, 0, 0, '0);
        drn_start = 1'b0;
        step();
        chk_drn("nostart1", 0, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule
